// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, byte FIFO and 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0010,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_raddr,
    input  logic        bus_re,
    input  logic [31:0] bus_waddr,
    input  logic        bus_we,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        uart_txd,
    output logic        tx_busy
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count, count_next;
    logic              overflow;
    logic              fifo_empty, fifo_full;
    logic              wr_data_hit, wr_status_hit;
    logic              push, pop, overflow_set, overflow_clr;
    logic [7:0]        head_byte;

    state_t            state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [2:0]        bit_idx, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              txd_next, busy_next;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit, parity_next;
`endif

    logic unused_wdata;
    assign unused_wdata = ^bus_wdata[31:8];

    assign fifo_empty    = (fifo_count == '0);
    assign fifo_full     = (fifo_count == CNT_FULL);
    assign head_byte     = fifo_mem[rd_ptr];
    assign wr_data_hit   = bus_we && (bus_waddr == BASE_ADDR);
    assign wr_status_hit = bus_we && (bus_waddr == STATUS_ADDR);
    // A push into a full FIFO still fits when the serialiser pops on the same edge.
    assign push          = wr_data_hit && (!fifo_full || pop);
    assign overflow_set  = wr_data_hit && fifo_full && !pop;
    assign overflow_clr  = wr_status_hit && bus_wdata[3];
    assign count_next    = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign busy_next     = (count_next != '0) || (state_next != IDLE);

    always_comb begin
        state_next  = state;
        baud_next   = (baud_cnt != '0) ? baud_cnt - 1'b1 : '0;
        bit_next    = bit_idx;
        shift_next  = shift_reg;
        txd_next    = uart_txd;
        pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_next  = head_byte;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^head_byte;
`endif
                    state_next  = START;
                    baud_next   = BAUD_RELOAD;
                    txd_next    = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    state_next = DATA;
                    baud_next  = BAUD_RELOAD;
                    bit_next   = 3'd0;
                    txd_next   = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_next = BAUD_RELOAD;
                    bit_next  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        txd_next   = parity_bit;
`else
                        state_next = STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        txd_next   = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_cnt == '0) begin
                    state_next = STOP;
                    baud_next  = BAUD_RELOAD;
                    txd_next   = 1'b1;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next START when more bytes are waiting.
                if (baud_cnt == '0) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shift_next  = head_byte;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^head_byte;
`endif
                        state_next  = START;
                        baud_next   = BAUD_RELOAD;
                        txd_next    = 1'b0;
                    end else begin
                        state_next  = IDLE;
                        txd_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            uart_txd   <= 1'b1;
            tx_busy    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= bit_next;
            shift_reg  <= shift_next;
            uart_txd   <= txd_next;
            tx_busy    <= busy_next;
            fifo_count <= count_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (overflow_set)      overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) fifo_mem[wr_ptr] <= bus_wdata[7:0];
    end

    always_comb begin
        bus_rdata = '0;
        if (bus_re && (bus_raddr == STATUS_ADDR)) begin
            bus_rdata[0]    = fifo_full;
            bus_rdata[1]    = fifo_empty;
            bus_rdata[2]    = (state != IDLE);
            bus_rdata[3]    = overflow;
            bus_rdata[15:8] = 8'(fifo_count);
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, checked every cycle
// against a timeline model that derives each frame's start cycle from write times.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h0001_0010;
    localparam logic [31:0] STAT  = 32'h0001_0014;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n, bus_re, bus_we;
    logic [31:0] bus_raddr, bus_waddr, bus_wdata, bus_rdata;
    logic        uart_txd, tx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Each accepted byte is remembered with the cycle its frame starts on the wire.
    int         ent_pop[$];
    logic [7:0] ent_dat[$];
    int         last_pop;
    logic       ovf_model;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_raddr(bus_raddr),
        .bus_re(bus_re),
        .bus_waddr(bus_waddr),
        .bus_we(bus_we),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .uart_txd(uart_txd),
        .tx_busy(tx_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (FRAME_BITS == 11 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    function automatic void model_edge(input int t, input logic rst_v, input logic we_v,
                                       input logic [31:0] waddr_v, input logic [31:0] wdata_v);
        int pending;
        int p;
        pending = 0;
        if (!rst_v) begin
            ent_pop.delete();
            ent_dat.delete();
            last_pop  = -100000;
            ovf_model = 1'b0;
        end else if (we_v && waddr_v == BASE) begin
            foreach (ent_pop[i]) if (ent_pop[i] > t) pending++;
            if (pending >= DEPTH) begin
                ovf_model = 1'b1;
            end else begin
                p = (last_pop + FRAME_CYC > t + 1) ? last_pop + FRAME_CYC : t + 1;
                ent_pop.push_back(p);
                ent_dat.push_back(wdata_v[7:0]);
                last_pop = p;
            end
        end else if (we_v && waddr_v == STAT && wdata_v[3]) begin
            ovf_model = 1'b0;
        end
        while (ent_pop.size() > 0 && ent_pop[0] + FRAME_CYC < t) begin
            void'(ent_pop.pop_front());
            void'(ent_dat.pop_front());
        end
    endfunction

    task automatic applyStimulus(input logic rst_v, input logic we_v, input logic [31:0] waddr_v,
                                 input logic [31:0] wdata_v, input logic re_v, input logic [31:0] raddr_v);
        logic        exp_txd, exp_busy, exp_act;
        int          cnt;
        logic [31:0] exp_r;
        rst_n     = rst_v;
        bus_we    = we_v;
        bus_waddr = waddr_v;
        bus_wdata = wdata_v;
        bus_re    = re_v;
        bus_raddr = raddr_v;
        @(posedge clk);
        cyc++;
        model_edge(cyc, rst_v, we_v, waddr_v, wdata_v);
        @(negedge clk);
        exp_txd  = 1'b1;
        exp_busy = 1'b0;
        exp_act  = 1'b0;
        cnt      = 0;
        foreach (ent_pop[i]) begin
            if (ent_pop[i] > cyc) cnt++;
            if (ent_pop[i] + FRAME_CYC > cyc) exp_busy = 1'b1;
            if (ent_pop[i] <= cyc && cyc < ent_pop[i] + FRAME_CYC) begin
                exp_act = 1'b1;
                exp_txd = frame_bit(ent_dat[i], (cyc - ent_pop[i]) / CPB);
            end
        end
        exp_r = '0;
        if (re_v && raddr_v == STAT) begin
            exp_r[0]    = (cnt == DEPTH);
            exp_r[1]    = (cnt == 0);
            exp_r[2]    = exp_act;
            exp_r[3]    = ovf_model;
            exp_r[15:8] = 8'(cnt);
        end
        checkOutput("txd", {31'd0, uart_txd}, {31'd0, exp_txd});
        checkOutput("tx_busy", {31'd0, tx_busy}, {31'd0, exp_busy});
        checkOutput("rdata", bus_rdata, exp_r);
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, STAT);
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, data, 1'b1, STAT);
    endtask

    initial begin
        int          dense;
        logic        we_r, re_r, rst_r;
        logic [31:0] wa, ra;
        int          sel;
        last_pop  = -100000;
        ovf_model = 1'b0;

        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, STAT);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, STAT);
        runIdle(3);

        writeReg(BASE, 32'hFFFF_FF55);
        runIdle(50);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, BASE);

        for (int i = 0; i < 10; i++) writeReg(BASE, 32'(i));
        runIdle(20);
        writeReg(STAT, 32'h0000_0000);
        runIdle(2);
        writeReg(STAT, 32'h0000_0008);
        runIdle(380);

        writeReg(BASE, 32'h0000_00A5);
        writeReg(BASE, 32'h0000_003C);
        runIdle(90);

        writeReg(BASE, 32'h0000_0007);
        runIdle(50);

        writeReg(BASE, 32'h0000_00C3);
        runIdle(17);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, STAT);
        runIdle(5);

        dense = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) dense = $urandom_range(0, 1);
            rst_r = ($urandom_range(0, 699) != 0);
            we_r  = dense ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            sel   = $urandom_range(0, 9);
            wa    = (sel < 6) ? BASE : (sel < 8) ? STAT : $urandom;
            sel   = $urandom_range(0, 9);
            ra    = (sel < 7) ? STAT : (sel < 9) ? BASE : $urandom;
            re_r  = ($urandom_range(0, 7) != 0);
            applyStimulus(rst_r, we_r, wa, $urandom, re_r, ra);
        end
        runIdle(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
